// File: rtl/ddr_read_cache_ctrl_pkg.sv
// Shared definitions for the DDR read cache controller.
// FSM state encodings and line-count derivation.
package ddr_read_cache_ctrl_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOOKUP    = 2'd1;
    localparam logic [1:0] ST_MISS_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LOOKUP    = ST_LOOKUP,
        MISS_WAIT = ST_MISS_WAIT,
        FLUSH     = ST_FLUSH
    } state_t;

    function automatic int num_lines(input int index_width);
        return 1 << index_width;
    endfunction

endpackage

// File: rtl/ddr_read_cache_ctrl_if.sv
// Request, output-mux and DDR read signals of the cache controller.
// The controller side is the slave; the requester/memory side is the master.
interface ddr_read_cache_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  ReadReq;
    logic [ADDR_WIDTH-1:0] Addr;
    logic                  Flush;
    logic                  Busy;
    logic                  DataValid;
    logic                  Select;
    logic [DATA_WIDTH-1:0] CashData;
    logic                  MemReadReq;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic                  MemReady;
    logic [DATA_WIDTH-1:0] MemData;

    modport master (
        output ReadReq, Addr, Flush, MemReady, MemData,
        input  Busy, DataValid, Select, CashData, MemReadReq, MemAddr
    );

    modport slave (
        input  ReadReq, Addr, Flush, MemReady, MemData,
        output Busy, DataValid, Select, CashData, MemReadReq, MemAddr
    );
endinterface

// File: rtl/ddr_read_cache_ctrl_tag_store.sv
// Direct-mapped valid/tag/data storage with one write port,
// one combinational read port, hit compare and per-line invalidate.
module cache_tag_store
    import ddr_read_cache_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              clr_en,
    input  logic [INDEX_WIDTH-1:0]            clr_idx,
    input  logic                              wr_en,
    input  logic [INDEX_WIDTH-1:0]            wr_idx,
    input  logic [ADDR_WIDTH-INDEX_WIDTH-1:0] wr_tag,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [INDEX_WIDTH-1:0]            rd_idx,
    input  logic [ADDR_WIDTH-INDEX_WIDTH-1:0] rd_tag,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              hit
);
    localparam int LINES = num_lines(INDEX_WIDTH);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    // Valid bits: cleared by reset, flush walk clears, fill sets.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid <= '0;
        end else begin
            if (clr_en) valid[clr_idx] <= 1'b0;
            if (wr_en)  valid[wr_idx]  <= 1'b1;
        end
    end

    // Tag and data payload, written on line fill only.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = data_mem[rd_idx];
    assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);

endmodule

// File: rtl/ddr_read_cache_ctrl.sv
// Direct-mapped read-only cache in front of a DDR read port.
// Hits return in the lookup cycle; misses forward DDR data through the mux.
module ddr_read_cache_ctrl
    import ddr_read_cache_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                 Clk,
    input  logic                 Rst,
    ddr_read_cache_ctrl_if.slave bus
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic                   mem_req_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [INDEX_WIDTH-1:0] flush_cnt;
    logic                   hit;
    logic                   fill;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign fill = (state == MISS_WAIT) && bus.MemReady;

    cache_tag_store #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_store (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr_en  (state == FLUSH),
        .clr_idx (flush_cnt),
        .wr_en   (fill),
        .wr_idx  (addr_reg[INDEX_WIDTH-1:0]),
        .wr_tag  (addr_reg[ADDR_WIDTH-1:INDEX_WIDTH]),
        .wr_data (bus.MemData),
        .rd_idx  (addr_reg[INDEX_WIDTH-1:0]),
        .rd_tag  (addr_reg[ADDR_WIDTH-1:INDEX_WIDTH]),
        .rd_data (rd_data),
        .hit     (hit)
    );

    // State register plus latched address, DDR request and flush walk.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            addr_reg   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            flush_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (!bus.Flush && bus.ReadReq) addr_reg <= bus.Addr;
                end
                LOOKUP: begin
                    if (!hit) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_reg;
                    end
                end
                MISS_WAIT: begin
                    if (bus.MemReady) mem_req_q <= 1'b0;
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.Flush)        state_nxt = FLUSH;
                else if (bus.ReadReq) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                state_nxt = hit ? IDLE : MISS_WAIT;
            end
            MISS_WAIT: begin
                if (bus.MemReady) state_nxt = IDLE;
            end
            FLUSH: begin
                if (flush_cnt == '1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and output-mux controls decoded from state.
    always_comb begin
        bus.Busy      = (state != IDLE);
        bus.Select    = (state == MISS_WAIT);
        bus.DataValid = ((state == LOOKUP) && hit) || fill;
    end

    assign bus.CashData   = rd_data;
    assign bus.MemReadReq = mem_req_q;
    assign bus.MemAddr    = mem_addr_q;

    logic unused_tag_w;
    assign unused_tag_w = (TAG_W > 0);

endmodule

// File: tb/tb_ddr_read_cache_ctrl.sv
// Directed testbench for ddr_read_cache_ctrl with a line-level cache model.
// Per-cycle compare process plus literal expectations per scenario.
module tb_ddr_read_cache_ctrl;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    always #5 Clk = ~Clk;

    ddr_read_cache_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    ddr_read_cache_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (16),
        .INDEX_WIDTH (6)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: what the cache holds, per line.
    bit         mvalid [64];
    logic [9:0] mtag   [64];
    logic [7:0] mdata  [64];

    logic [15:0] cur_addr = '0;
    logic [7:0]  last_cash;
    bit          in_flush = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return mvalid[a[5:0]] && (mtag[a[5:0]] == a[15:6]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 0;
    endtask

    // Every-cycle compare against the model.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (!bus.Busy) begin
                check("idle_dv", bus.DataValid, 0);
                check("idle_sel", bus.Select, 0);
                check("idle_mrq", bus.MemReadReq, 0);
            end
            if (in_flush) check("flush_dv", bus.DataValid, 0);
            if (bus.DataValid && !bus.Select) begin
                check("cyc_hit", model_hit(cur_addr), 1);
                check("cyc_cash", bus.CashData, mdata[cur_addr[5:0]]);
            end
            if (bus.DataValid && bus.Select)
                check("cyc_memrdy", bus.MemReady, 1);
            if (bus.Select)
                check("cyc_sel_mrq", bus.MemReadReq, 1);
        end
    end

    // One read; starts and ends one time unit after a rising edge.
    task automatic do_read(input logic [15:0] a, input int lat,
                           input logic [7:0] d, output bit was_hit);
        bit h;
        h = model_hit(a);
        was_hit = h;
        check("pre_busy", bus.Busy, 0);
        cur_addr    = a;
        bus.Addr    = a;
        bus.ReadReq = 1;
        @(posedge Clk); #1;
        bus.ReadReq = 0;
        #1;
        check("lk_busy", bus.Busy, 1);
        check("lk_dv", bus.DataValid, h);
        check("lk_sel", bus.Select, 0);
        check("lk_mrq", bus.MemReadReq, 0);
        if (h) begin
            check("lk_cash", bus.CashData, mdata[a[5:0]]);
            last_cash = bus.CashData;
            @(posedge Clk); #1;
        end else begin
            for (int k = 0; k < lat; k++) begin
                @(posedge Clk); #1;
                check("mw_mrq", bus.MemReadReq, 1);
                check("mw_maddr", bus.MemAddr, a);
                check("mw_sel", bus.Select, 1);
                check("mw_busy", bus.Busy, 1);
                check("mw_dv", bus.DataValid, 0);
            end
            bus.MemData  = d;
            bus.MemReady = 1;
            #1;
            check("fill_dv", bus.DataValid, 1);
            check("fill_sel", bus.Select, 1);
            @(posedge Clk); #1;
            bus.MemReady = 0;
            mvalid[a[5:0]] = 1;
            mtag[a[5:0]]   = a[15:6];
            mdata[a[5:0]]  = d;
        end
        check("post_busy", bus.Busy, 0);
        check("post_mrq", bus.MemReadReq, 0);
        check("post_sel", bus.Select, 0);
    endtask

    initial begin
        bit h;
        int n;
        logic [15:0] b2b [8];
        bus.ReadReq  = 0;
        bus.Addr     = '0;
        bus.Flush    = 0;
        bus.MemReady = 0;
        bus.MemData  = '0;
        model_clear();

        // Reset state
        #12;
        check("rst_busy", bus.Busy, 0);
        check("rst_dv", bus.DataValid, 0);
        check("rst_sel", bus.Select, 0);
        check("rst_mrq", bus.MemReadReq, 0);
        check("rst_maddr", bus.MemAddr, 0);
        Rst = 0;
        @(posedge Clk); #1;

        // Cold miss then hit after fill
        do_read(16'h0123, 5, 8'hA5, h);
        check("cold_is_miss", h, 0);
        do_read(16'h0123, 0, 8'h00, h);
        check("refill_hit", h, 1);
        check("refill_data", last_cash, 8'hA5);

        // Conflict on index 0
        do_read(16'h0040, 2, 8'h11, h);
        check("c1_miss", h, 0);
        do_read(16'h0440, 3, 8'h22, h);
        check("c2_miss", h, 0);
        do_read(16'h0040, 1, 8'h11, h);
        check("c3_miss", h, 0);
        do_read(16'h0040, 0, 8'h00, h);
        check("c4_data", last_cash, 8'h11);

        // Flush with simultaneous ReadReq
        do_read(16'h0201, 1, 8'h31, h);
        do_read(16'h0302, 1, 8'h32, h);
        do_read(16'h003F, 1, 8'h33, h);
        bus.Flush   = 1;
        bus.ReadReq = 1;
        bus.Addr    = 16'h0201;
        in_flush    = 1;
        @(posedge Clk); #1;
        bus.Flush   = 0;
        bus.ReadReq = 0;
        n = 0;
        for (int k = 0; k < 100 && bus.Busy; k++) begin
            n++;
            check("fl_mrq", bus.MemReadReq, 0);
            @(posedge Clk); #1;
        end
        in_flush = 0;
        model_clear();
        check("flush_len", n, 64);
        do_read(16'h0201, 1, 8'h41, h);
        check("fl_miss0", h, 0);
        do_read(16'h0302, 1, 8'h42, h);
        check("fl_miss1", h, 0);
        do_read(16'h003F, 1, 8'h43, h);
        check("fl_miss2", h, 0);

        // Reset during a miss; late DDR response ignored
        bus.Addr    = 16'h0205;
        cur_addr    = 16'h0205;
        bus.ReadReq = 1;
        @(posedge Clk); #1;
        bus.ReadReq = 0;
        repeat (3) @(posedge Clk);
        #1;
        check("mm_mrq_before", bus.MemReadReq, 1);
        #1 Rst = 1;
        #1;
        check("mm_mrq", bus.MemReadReq, 0);
        check("mm_sel", bus.Select, 0);
        check("mm_busy", bus.Busy, 0);
        model_clear();
        @(posedge Clk); #2;
        Rst = 0;
        bus.MemData  = 8'hFF;
        bus.MemReady = 1;
        #1;
        check("late_dv", bus.DataValid, 0);
        @(posedge Clk); #1;
        bus.MemReady = 0;
        check("late_dv2", bus.DataValid, 0);
        do_read(16'h0205, 2, 8'h3C, h);
        check("late_nofill", h, 0);
        do_read(16'h0205, 0, 8'h00, h);
        check("late_data", last_cash, 8'h3C);

        // Back-to-back hits
        for (int i = 0; i < 8; i++) begin
            b2b[i] = 16'h1000 + 16'(i * 67);
            do_read(b2b[i], 1, 8'(8'h80 + i), h);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(b2b[i], 0, 8'h00, h);
            check("b2b_hit", h, 1);
            check("b2b_data", last_cash, 8'(8'h80 + i));
        end

        repeat (2) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_read_cache_ctrl.md
Name: ddr_read_cache_ctrl

Overview:
Direct-mapped, read-only, one-word-per-line cache controller that feeds the downstream output data multiplexer. It accepts read requests from the DownSample datapath and looks up the tag store. On a hit it presents cached data with Select=0. On a miss it fetches from the DDR memory interface, fills the line, and drives Select=1 so the multiplexer forwards MemData.

Parameters:
DATA_WIDTH, 8, data word width (matches the output multiplexer).
ADDR_WIDTH, 16, word address width.
INDEX_WIDTH, 6, line index bits; NUM_LINES = 2**INDEX_WIDTH = 64.

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
ReadReq  input  1  read request; sampled only when Busy=0
Addr  input  ADDR_WIDTH  word address, sampled with ReadReq
Flush  input  1  invalidate all lines; sampled only when Busy=0
Busy  output  1  controller not accepting ReadReq/Flush
DataValid  output  1  one-cycle strobe: output-mux data is valid this cycle
Select  output  1  to output mux: 1 = MemData, 0 = CashData
CashData  output  DATA_WIDTH  to output mux: data word of addressed line
MemReadReq  output  1  DDR read request, held until MemReady
MemAddr  output  ADDR_WIDTH  DDR word address
MemReady  input  1  DDR read data valid on MemData this cycle
MemData  input  DATA_WIDTH  DDR read data (also routed to output mux)

Behaviour:
- Storage per line: valid bit, tag [ADDR_WIDTH-INDEX_WIDTH], data [DATA_WIDTH]. Index = Addr[INDEX_WIDTH-1:0]; tag = upper bits.
- FSM states: IDLE, LOOKUP, MISS_WAIT, FLUSH.
- IDLE: Busy=0.
  - Flush=1: go to FLUSH. Flush has priority over a simultaneous ReadReq, which is dropped.
  - Else ReadReq=1: latch Addr into AddrReg, go to LOOKUP.
- LOOKUP: Busy=1; CashData = data[index(AddrReg)] (combinational array read).
  - Hit (valid && tag match): DataValid=1, Select=0 this cycle; go to IDLE. Hit latency is 1 cycle after the accept edge.
  - Miss: go to MISS_WAIT; MemReadReq=1 and MemAddr=AddrReg both registered, asserted from the next cycle.
- MISS_WAIT: Busy=1, Select=1, MemReadReq=1 held stable.
  - On MemReady=1: DataValid=1 in the same cycle (combinational), so the mux forwards MemData.
  - At that edge, write MemData/tag into the line and set valid; clear MemReadReq and Select; go to IDLE.
  - MemReady outside MISS_WAIT is ignored.
- FLUSH: Busy=1; a counter of INDEX_WIDTH bits clears one valid bit per cycle, from 0 to NUM_LINES-1 (64 cycles). It wraps to 0 and returns to IDLE after the last line.
- Back-to-back: a ReadReq on the cycle Busy drops is accepted. A re-read of a just-filled address hits.
- Select is 0 in every state except MISS_WAIT. DataValid is never asserted in IDLE or FLUSH.
- Reset (asynchronous, any state, including mid-miss or mid-flush):
  - state=IDLE; all valid bits=0; flush counter=0; AddrReg=0.
  - MemReadReq=0, MemAddr=0, Select=0, DataValid=0, Busy=0.
  - Tag/data arrays are not reset.
  - An in-flight DDR response arriving after reset is ignored.

Decomposition:
- Shared package/include: FSM state encodings (2-bit localparams) and the NUM_LINES derivation.
- One sub-module, cache_tag_store: valid/tag/data arrays with async-clear valid vector, write port, combinational read port and hit compare.

Test Plan:
- Cold miss: Rst, then ReadReq Addr=0x0123 → MemReadReq=1, MemAddr=0x0123 held. MemReady after 5 cycles with MemData=0xA5 → DataValid=1 and Select=1 on that cycle; Busy returns 0 on the next edge.
- Hit after fill: ReadReq Addr=0x0123 → LOOKUP cycle with DataValid=1, Select=0, CashData=0xA5; no MemReadReq.
- Conflict: fill 0x0040 (data 0x11), then read 0x0440 (same index 0) → miss; fill 0x22. Re-read 0x0040 → miss again.
- Flush: fill 3 lines; assert Flush → Busy high exactly 64 cycles; re-reads all miss. Flush and ReadReq together → ReadReq ignored.
- Reset mid-miss: assert Rst during MISS_WAIT → MemReadReq, Select, Busy go 0 immediately (async). Late MemReady/MemData=0xFF → no DataValid, no fill.
- Back-to-back hits: 8 consecutive hit reads, each issued the cycle Busy drops → one DataValid per request, Select always 0, correct CashData.
